// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: architectural
// sizes (shared with the register file), dump sequencer states and small helpers.
package regfile_access_ctrl_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    // The scan pointer carries one extra bit so it can step past the last
    // register index without wrapping back to zero.
    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STALL_WAIT,
        SCAN,
        DRAIN
    } dump_state_t;

    // Register $0 is hard-wired to zero, so writes to it are dropped.
    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

    // The dump sequencer owns read port 1 once the pipeline is frozen.
    function automatic logic owns_read_port(input dump_state_t s);
        return (s == SCAN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Signal bundle between the pipeline/debug environment and the register-file
// access controller. The slave modport is the controller's view.
interface regfile_access_ctrl_if;
    import regfile_access_ctrl_pkg::*;

    // Writeback write port
    logic              wb_reg_write;
    logic [ADDR_W-1:0] wb_write_register;
    logic [DATA_W-1:0] wb_write_data;

    // Debug write requester
    logic              dbg_wr_valid;
    logic              dbg_wr_ready;
    logic [ADDR_W-1:0] dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;

    // Read port 1 path
    logic [ADDR_W-1:0] id_read_register_1;
    logic [ADDR_W-1:0] rf_read_register_1;
    logic [DATA_W-1:0] rf_read_data_1;

    // Register file write port
    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_write_register;
    logic [DATA_W-1:0] rf_write_data;

    // Pipeline freeze handshake
    logic              stall_req;
    logic              stall_ack;

    // Dump control and beat stream
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    modport slave (
        input  wb_reg_write, wb_write_register, wb_write_data,
        input  dbg_wr_valid, dbg_wr_addr, dbg_wr_data,
        output dbg_wr_ready,
        input  id_read_register_1, rf_read_data_1,
        output rf_read_register_1,
        output rf_reg_write, rf_write_register, rf_write_data,
        output stall_req,
        input  stall_ack,
        input  dump_start, dump_ready,
        output dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );

    modport master (
        output wb_reg_write, wb_write_register, wb_write_data,
        output dbg_wr_valid, dbg_wr_addr, dbg_wr_data,
        input  dbg_wr_ready,
        output id_read_register_1, rf_read_data_1,
        input  rf_read_register_1,
        input  rf_reg_write, rf_write_register, rf_write_data,
        input  stall_req,
        output stall_ack,
        output dump_start, dump_ready,
        input  dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );

endinterface

// File: rtl/regfile_dump_seq.sv
// Register dump sequencer: freezes the pipeline, walks read port 1 over every
// architectural register and presents each value as a valid/ready beat.
module regfile_dump_seq
    import regfile_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    input  logic              stall_ack,
    input  logic              dump_ready,
    input  logic [DATA_W-1:0] rf_read_data_1,
    output dump_state_t       state,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              stall_req,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    dump_state_t       state_next;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic              stall_req_next;
    logic              dump_busy_next;
    logic              dump_valid_next;
    logic [ADDR_W-1:0] dump_addr_next;
    logic [DATA_W-1:0] dump_data_next;
    logic              dump_done_next;

    // State, pointer and beat register; reset aborts any dump in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            stall_req  <= 1'b0;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            stall_req  <= stall_req_next;
            dump_busy  <= dump_busy_next;
            dump_valid <= dump_valid_next;
            dump_addr  <= dump_addr_next;
            dump_data  <= dump_data_next;
            dump_done  <= dump_done_next;
        end
    end

    // Next-state logic: a beat is loaded whenever the output slot is empty or
    // being consumed, so a stalled beat holds its address and data unchanged.
    always_comb begin
        state_next      = state;
        ptr_next        = ptr;
        stall_req_next  = stall_req;
        dump_busy_next  = dump_busy;
        dump_valid_next = dump_valid;
        dump_addr_next  = dump_addr;
        dump_data_next  = dump_data;
        dump_done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next     = STALL_WAIT;
                    stall_req_next = 1'b1;
                    dump_busy_next = 1'b1;
                    ptr_next       = '0;
                end
            end
            STALL_WAIT: begin
                if (stall_ack) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!dump_valid || dump_ready) begin
                    dump_data_next  = rf_read_data_1;
                    dump_addr_next  = ptr[ADDR_W-1:0];
                    dump_valid_next = 1'b1;
                    ptr_next        = ptr + PTR_W'(1);
                    if (ptr == LAST_PTR) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (dump_valid && dump_ready) begin
                    dump_valid_next = 1'b0;
                    stall_req_next  = 1'b0;
                    dump_busy_next  = 1'b0;
                    dump_done_next  = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign scan_addr = ptr[ADDR_W-1:0];

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: arbitrates the write port between
// writeback and a debug requester, and lends read port 1 to the dump sequencer.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_access_ctrl_if.slave bus
);

    dump_state_t       state;
    logic [ADDR_W-1:0] scan_addr;
    logic              dbg_ready;

    regfile_dump_seq u_dump_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .dump_start     (bus.dump_start),
        .stall_ack      (bus.stall_ack),
        .dump_ready     (bus.dump_ready),
        .rf_read_data_1 (bus.rf_read_data_1),
        .state          (state),
        .scan_addr      (scan_addr),
        .stall_req      (bus.stall_req),
        .dump_busy      (bus.dump_busy),
        .dump_valid     (bus.dump_valid),
        .dump_addr      (bus.dump_addr),
        .dump_data      (bus.dump_data),
        .dump_done      (bus.dump_done)
    );

    // Debug writes only slip into idle write-port cycles, and never while a
    // dump is running, so the dumped snapshot stays consistent.
    assign dbg_ready        = (state == IDLE) && !bus.wb_reg_write;
    assign bus.dbg_wr_ready = dbg_ready;

    // Write-port mux: writeback wins, debug fills gaps, $0 is never written.
    always_comb begin
        bus.rf_reg_write      = 1'b0;
        bus.rf_write_register = bus.wb_write_register;
        bus.rf_write_data     = bus.wb_write_data;
        if (bus.wb_reg_write) begin
            bus.rf_reg_write = is_writable(bus.wb_write_register);
        end else if (bus.dbg_wr_valid && dbg_ready) begin
            bus.rf_reg_write      = is_writable(bus.dbg_wr_addr);
            bus.rf_write_register = bus.dbg_wr_addr;
            bus.rf_write_data     = bus.dbg_wr_data;
        end
    end

    // Read port 1 follows the ID stage except while the dump is scanning.
    assign bus.rf_read_register_1 = owns_read_port(state) ? scan_addr
                                                          : bus.id_read_register_1;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: models the register file, drives directed
// and random write traffic, and runs full, back-pressured and aborted dumps.
module tb_regfile_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    regfile_access_ctrl_if bus();

    regfile_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file storage (environment) and expected contents (reference).
    logic [31:0] rf_mem   [32];
    logic [31:0] exp_regs [32];
    logic [31:0] snap     [32];
    bit          model_busy;
    int          passed;
    int          total;

    assign bus.rf_read_data_1 = rf_mem[bus.rf_read_register_1];

    // Register file commits on the rising edge, like the real one.
    always @(posedge clk) begin
        if (bus.rf_reg_write) rf_mem[bus.rf_write_register] <= bus.rf_write_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_stall_req"},  32'(bus.stall_req),  32'd0);
        checkOutput({tag, "_dump_busy"},  32'(bus.dump_busy),  32'd0);
        checkOutput({tag, "_dump_valid"}, 32'(bus.dump_valid), 32'd0);
        checkOutput({tag, "_dump_addr"},  32'(bus.dump_addr),  32'd0);
        checkOutput({tag, "_dump_data"},  bus.dump_data,       32'd0);
        checkOutput({tag, "_dump_done"},  32'(bus.dump_done),  32'd0);
    endtask

    // One write-port cycle: expected behaviour derived from the arbitration rules.
    task automatic applyStimulus(input bit wbw, input logic [4:0] wba, input logic [31:0] wbd,
                                 input bit dv, input logic [4:0] da, input logic [31:0] dd,
                                 input logic [4:0] ida);
        bit          exp_ready;
        bit          exp_we;
        bit          touched;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        @(negedge clk);
        bus.wb_reg_write       = wbw;
        bus.wb_write_register  = wba;
        bus.wb_write_data      = wbd;
        bus.dbg_wr_valid       = dv;
        bus.dbg_wr_addr        = da;
        bus.dbg_wr_data        = dd;
        bus.id_read_register_1 = ida;
        #1;
        exp_ready = !model_busy && !wbw;
        exp_we    = 1'b0;
        exp_a     = wba;
        exp_d     = wbd;
        touched   = 1'b0;
        if (wbw) begin
            exp_we  = (wba != 5'd0);
            touched = 1'b1;
        end else if (dv && exp_ready) begin
            exp_we  = (da != 5'd0);
            exp_a   = da;
            exp_d   = dd;
            touched = 1'b1;
        end
        checkOutput("dbg_wr_ready", 32'(bus.dbg_wr_ready), 32'(exp_ready));
        checkOutput("rf_reg_write", 32'(bus.rf_reg_write), 32'(exp_we));
        if (exp_we) begin
            checkOutput("rf_write_register", 32'(bus.rf_write_register), 32'(exp_a));
            checkOutput("rf_write_data", bus.rf_write_data, exp_d);
        end
        checkOutput("rf_read_register_1", 32'(bus.rf_read_register_1), 32'(ida));
        checkOutput("rf_read_data_1", bus.rf_read_data_1, exp_regs[ida]);
        @(posedge clk);
        #1;
        if (exp_we) exp_regs[exp_a] = exp_d;
        if (touched) checkOutput("rf_content", rf_mem[exp_a], exp_regs[exp_a]);
    endtask

    // Full dump with optional random back-pressure and optional reset abort
    // after a given number of accepted beats (0 = run to completion).
    task automatic runDump(input bit random_ready, input int abort_after);
        int          beats;
        int          cycles;
        bit          done_seen;
        bit          aborted;
        bit          hold_pending;
        logic [4:0]  held_addr;
        logic [31:0] held_data;
        logic [4:0]  id_addr;
        for (int i = 0; i < 32; i++) snap[i] = exp_regs[i];
        @(negedge clk);
        bus.wb_reg_write = 1'b0;
        bus.dbg_wr_valid = 1'b0;
        bus.dump_ready   = 1'b1;
        bus.stall_ack    = 1'b0;
        bus.dump_start   = 1'b1;
        @(posedge clk);
        #1;
        model_busy = 1'b1;
        checkOutput("start_stall_req", 32'(bus.stall_req), 32'd1);
        checkOutput("start_dump_busy", 32'(bus.dump_busy), 32'd1);
        @(negedge clk);
        bus.dump_start   = 1'b0;
        id_addr          = 5'($urandom_range(0, 31));
        bus.id_read_register_1 = id_addr;
        bus.dbg_wr_valid = 1'b1;
        bus.dbg_wr_addr  = 5'($urandom_range(1, 31));
        bus.dbg_wr_data  = $urandom;
        #1;
        checkOutput("wait_dbg_wr_ready", 32'(bus.dbg_wr_ready), 32'd0);
        checkOutput("wait_rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
        checkOutput("wait_read_addr", 32'(bus.rf_read_register_1), 32'(id_addr));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wait_stall_req", 32'(bus.stall_req), 32'd1);
        checkOutput("wait_no_valid", 32'(bus.dump_valid), 32'd0);
        @(negedge clk);
        bus.stall_ack = 1'b1;
        beats = 0;
        cycles = 0;
        done_seen = 1'b0;
        aborted = 1'b0;
        hold_pending = 1'b0;
        held_addr = '0;
        held_data = '0;
        while (!done_seen && !aborted && cycles < 400) begin
            @(posedge clk);
            cycles++;
            #1;
            if (hold_pending) begin
                checkOutput("hold_valid", 32'(bus.dump_valid), 32'd1);
                checkOutput("hold_addr", 32'(bus.dump_addr), 32'(held_addr));
                checkOutput("hold_data", bus.dump_data, held_data);
            end
            if (bus.dump_done) begin
                done_seen = 1'b1;
                bus.dbg_wr_valid = 1'b0;
                checkOutput("done_beats", beats, (abort_after > 0) ? 32'd0 : 32'd32);
                checkOutput("done_stall_req", 32'(bus.stall_req), 32'd0);
                checkOutput("done_dump_busy", 32'(bus.dump_busy), 32'd0);
                checkOutput("done_dump_valid", 32'(bus.dump_valid), 32'd0);
                if (!random_ready) checkOutput("done_latency", cycles, 32'd34);
            end else begin
                @(negedge clk);
                bus.dump_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (random_ready && cycles == 8) bus.stall_ack = 1'b0;
                bus.dump_start = (cycles == 15);
                bus.dbg_wr_addr = 5'($urandom_range(1, 31));
                bus.dbg_wr_data = $urandom;
                #1;
                checkOutput("scan_dbg_wr_ready", 32'(bus.dbg_wr_ready), 32'd0);
                checkOutput("scan_rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
                hold_pending = bus.dump_valid && !bus.dump_ready;
                held_addr = bus.dump_addr;
                held_data = bus.dump_data;
                if (bus.dump_valid && bus.dump_ready) begin
                    checkOutput("beat_addr", 32'(bus.dump_addr), beats);
                    checkOutput("beat_data", bus.dump_data, snap[beats[4:0]]);
                    beats++;
                    if (abort_after > 0 && beats == abort_after) begin
                        bus.dbg_wr_valid = 1'b0;
                        bus.dump_start = 1'b0;
                        rst_n = 1'b0;
                        #1;
                        checkResetValues("abort");
                        @(posedge clk);
                        #1;
                        checkResetValues("abort_held");
                        @(negedge clk);
                        bus.stall_ack  = 1'b0;
                        bus.dump_ready = 1'b0;
                        rst_n = 1'b1;
                        aborted = 1'b1;
                    end
                end
            end
        end
        if (abort_after > 0) checkOutput("abort_reached", 32'(aborted), 32'd1);
        else checkOutput("dump_completed", 32'(done_seen), 32'd1);
        bus.dbg_wr_valid = 1'b0;
        bus.dump_start   = 1'b0;
        bus.stall_ack    = 1'b0;
        model_busy = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("after_dump_done", 32'(bus.dump_done), 32'd0);
        checkOutput("after_dump_busy", 32'(bus.dump_busy), 32'd0);
        checkOutput("after_stall_req", 32'(bus.stall_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        passed = 0;
        total = 0;
        model_busy = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i]   = '0;
            exp_regs[i] = '0;
        end
        rst_n = 1'b0;
        bus.wb_reg_write       = 1'b0;
        bus.wb_write_register  = '0;
        bus.wb_write_data      = '0;
        bus.dbg_wr_valid       = 1'b0;
        bus.dbg_wr_addr        = '0;
        bus.dbg_wr_data        = '0;
        bus.id_read_register_1 = '0;
        bus.stall_ack          = 1'b0;
        bus.dump_start         = 1'b0;
        bus.dump_ready         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        checkOutput("reset_rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_dbg_wr_ready", 32'(bus.dbg_wr_ready), 32'd1);
        $display("[TB] reset checks done");

        // Writeback priority over debug, then debug takes the idle cycle
        applyStimulus(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22, 5'd9);
        applyStimulus(1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h22, 5'd9);
        checkOutput("prio_final_r9", rf_mem[9], 32'h22);

        // $0 protection: handshake completes, nothing is written
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0);
        checkOutput("r0_stays_zero", rf_mem[0], 32'h0);
        applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 5'd0);
        checkOutput("r0_wb_zero", rf_mem[0], 32'h0);

        // Random mixed writeback/debug traffic
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          5'($urandom_range(0, 31)));
        end
        $display("[TB] random write traffic done");

        // Preload $n = n*4 through the writeback port
        for (int n = 0; n < 32; n++) begin
            applyStimulus(1'b1, 5'(n), 32'(n * 4), 1'b0, 5'd0, 32'h0, 5'(n));
        end

        // Full-speed dump
        runDump(1'b0, 0);
        $display("[TB] full-speed dump done");

        // Debug writes resume after the dump
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hA5A5_0003, 5'd3);

        // Back-pressured dump with stall_ack dropping and a stray dump_start
        runDump(1'b1, 0);
        $display("[TB] back-pressured dump done");

        // Reset mid-dump after beat 10, then a complete dump from address 0
        runDump(1'b1, 11);
        checkResetValues("post_abort");
        runDump(1'b0, 0);
        $display("[TB] abort and restart done");

        applyStimulus(1'b1, 5'd7, 32'h7777, 1'b1, 5'd8, 32'h8888, 5'd7);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h8888, 5'd8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Arbiter and sequencer in front of the pipeline register file's write port and read port 1. Write path: writeback traffic always has priority; a debug write requester is granted only on idle cycles. Dump sequencer: on request it stalls the pipeline, takes over read port 1, and streams all registers $0–$31 out through a valid/ready beat interface for the board display and debug host. Sits between the WB/ID stages and the register file; pipeline timing is unchanged when no debug activity is present.

## Interface
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_reg_write  in  1  writeback write enable
- wb_write_register  in  ADDR_W  writeback destination
- wb_write_data  in  DATA_W  writeback data
- dbg_wr_valid  in  1  debug write request
- dbg_wr_ready  out  1  debug write grant
- dbg_wr_addr  in  ADDR_W  debug write destination
- dbg_wr_data  in  DATA_W  debug write data
- id_read_register_1  in  ADDR_W  ID-stage read address 1
- rf_read_register_1  out  ADDR_W  to register file read address 1
- rf_read_data_1  in  DATA_W  from register file, combinational read
- rf_reg_write  out  1  to register file write enable
- rf_write_register  out  ADDR_W  to register file write address
- rf_write_data  out  DATA_W  to register file write data
- stall_req  out  1  request pipeline freeze
- stall_ack  in  1  pipeline frozen and WB drained
- dump_start  in  1  start a full register dump (pulse or level)
- dump_busy  out  1  high from accepted start until dump_done
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  dump beat consumed
- dump_addr  out  ADDR_W  register index of current beat
- dump_data  out  DATA_W  register value of current beat
- dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Reset values: state IDLE, stall_req 0, dump_busy 0, dump_valid 0, dump_addr 0, dump_data 0, dump_done 0, scan pointer 0.
- Write arbitration (combinational, same cycle): wb_reg_write=1 → rf_* driven from wb_*. Else dbg_wr_valid && dbg_wr_ready → rf_* from dbg_*. Else rf_reg_write 0.
- dbg_wr_ready = (state==IDLE) && !wb_reg_write. Debug writes are never accepted during a dump (snapshot consistency).
- Any write (either source) with address 0 is forced to rf_reg_write 0; dbg handshake still completes.
- rf_read_register_1 = id_read_register_1 in IDLE and STALL_WAIT; scan pointer in SCAN and DRAIN.
- FSM:
  - IDLE: dump_start → STALL_WAIT, stall_req 1, dump_busy 1, pointer 0.
  - STALL_WAIT: stall_ack → SCAN.
  - SCAN: each cycle where !dump_valid || dump_ready: capture rf_read_data_1 → dump_data, pointer → dump_addr, dump_valid 1, pointer++. Capturing index NUM_REGS-1 → DRAIN.
  - DRAIN: dump_valid && dump_ready → dump_valid 0, stall_req 0, dump_busy 0, dump_done pulse, → IDLE.
- Pointer is ADDR_W+... wide enough not to wrap before the DRAIN transition; exactly NUM_REGS beats, addresses 0..NUM_REGS-1 ascending.
- A wb write occurring during SCAN (should not after stall_ack) is still applied; beats already captured are not revised.
- dump_start while dump_busy: ignored. stall_ack dropping mid-SCAN: no effect, scan continues.
- rst_n asserted mid-dump: immediate abort to reset values, no dump_done.

## Timing
- Write path: zero added latency; register file commits on the same clk edge as without this block.
- Dump: first beat valid 1 cycle after SCAN entry; with dump_ready held 1, one beat per cycle, last beat valid SCAN+32 cycles, dump_done one cycle after its acceptance.
- dump_valid/data/addr stable while dump_valid && !dump_ready.
- stall_req rises the cycle after dump_start accepted; falls the cycle after the last beat is accepted.

## Structure
- Shared package: FSM state enum (IDLE, STALL_WAIT, SCAN, DRAIN), NUM_REGS/ADDR_W/DATA_W constants shared with the register file.
- One natural sub-module: regfile_dump_seq (FSM, pointer, beat register); write arbitration stays in the top.

## Test plan
- Reset: rst_n low → all outputs 0, dbg_wr_ready 1 once rst_n high with wb idle.
- Priority: wb_reg_write=1 to $9=0x11, dbg write $9=0x22 same cycle → rf_write_data 0x11, dbg_wr_ready 0; next cycle (wb idle) dbg accepted, $9=0x22.
- $0 protection: dbg write $0=0xFFFFFFFF → handshake completes, rf_reg_write 0, $0 reads 0.
- Full dump, dump_ready=1, $n preloaded with n*4 → stall_req until stall_ack, 32 beats addr 0..31 data 0..124, dump_done once, stall_req low after.
- Backpressure: dump_ready toggled 1/0 → no beat lost or duplicated, data stable while stalled, beat 31 followed by dump_done.
- Reset mid-dump at beat 10 → all outputs return to reset values, no dump_done; new dump_start runs complete from addr 0.
